wb_arbiter: RTL and testbench

Writeback arbiter for the 32-bit RISC-V core. It sits between the execution units and the register file write port (RegW/Rd/Wd) and merges two result sources onto that single port. The single-cycle ALU pipeline has fixed priority. Long-latency load/store results enter through a valid/ready handshake into a small FIFO. A pending-destination scoreboard tells issue logic which registers still await a long-latency result.

---
 rtl/wb_arbiter.sv | 96 +++++++++
 tb/tb_wb_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a fixed-priority ALU result stream and a FIFO-buffered
// LSU result stream onto the single register-file write port, plus a pending-rd scoreboard.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_wd,
  output logic        lsu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        RegW,
  output logic [4:0]  Rd,
  output logic [31:0] Wd,
  output logic [31:0] pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wb_entry_t;

  wb_entry_t         mem [FIFO_DEPTH];
  wb_entry_t         head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              alu_win, push, pop;
  logic [31:0]       pending_nxt;

  assign lsu_ready = reset && (count < CW'(FIFO_DEPTH));
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  // x0 results complete the handshake but are never buffered
  assign push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign pop       = !alu_win && (count != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: lsu_rd, wd: lsu_wd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegW <= 1'b0;
      Rd   <= '0;
      Wd   <= '0;
    end else if (alu_win) begin
      RegW <= 1'b1;
      Rd   <= alu_rd;
      Wd   <= alu_wd;
    end else if (pop) begin
      RegW <= 1'b1;
      Rd   <= head.rd;
      Wd   <= head.wd;
    end else begin
      RegW <= 1'b0;
    end
  end

  // clear on pop first so a same-edge issue to that register wins
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head.rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
`timescale 1ns/1ps
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, iss_valid;
  logic [4:0]  alu_rd, lsu_rd, iss_rd;
  logic [31:0] alu_wd, lsu_wd;
  logic        lsu_ready, RegW;
  logic [4:0]  Rd;
  logic [31:0] Wd, pending;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .RegW(RegW), .Rd(Rd), .Wd(Wd), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_wd = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  int j;
  logic        exp_rdy [12];
  logic [4:0]  exp_rd  [12];
  logic [31:0] exp_wd  [12];

  initial begin
    idle();
    reset = 1'b0;
    #12;
    chk("rst_regw", RegW, 0);
    chk("rst_rd", Rd, 0);
    chk("rst_wd", Wd, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", lsu_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_ready", lsu_ready, 1);
    @(negedge clk);

    // ALU path, then an x0 ALU result that must be dropped
    alu_valid = 1; alu_rd = 5; alu_wd = 32'h1234;
    step();
    chk("alu_regw", RegW, 1);
    chk("alu_rd", Rd, 5);
    chk("alu_wd", Wd, 32'h1234);
    alu_rd = 0; alu_wd = 32'hFFFF;
    step();
    chk("alu_x0_regw", RegW, 0);
    chk("alu_x0_rd_hold", Rd, 5);
    chk("alu_x0_wd_hold", Wd, 32'h1234);
    idle();

    // LSU path with scoreboard
    iss_valid = 1; iss_rd = 7;
    step();
    chk("iss_set", pending, 32'h80);
    idle();
    lsu_valid = 1; lsu_rd = 7; lsu_wd = 32'hDEADBEEF;
    step();
    chk("lsu_lat_regw", RegW, 0);
    chk("lsu_lat_pend", pending, 32'h80);
    idle();
    step();
    chk("lsu_regw", RegW, 1);
    chk("lsu_rd", Rd, 7);
    chk("lsu_wd", Wd, 32'hDEADBEEF);
    chk("lsu_pend_clr", pending, 0);
    step();
    chk("lsu_once", RegW, 0);

    // LSU x0 handshake is consumed but never written
    lsu_valid = 1; lsu_rd = 0; lsu_wd = 32'h5555;
    step();
    idle();
    step();
    chk("lsu_x0_regw", RegW, 0);
    step();
    chk("lsu_x0_regw2", RegW, 0);

    // contention: ALU holds the port 6 cycles while LSU fills the FIFO
    for (int c = 0; c < 12; c++) begin
      exp_rdy[c] = !(c == 4 || c == 5 || c == 6);
      exp_rd[c]  = 5'd1;
      exp_wd[c]  = 32'd100 + 32'(c);
    end
    for (int c = 6; c < 11; c++) begin
      exp_rd[c] = 5'(10 + c - 6);
      exp_wd[c] = 32'(200 + c - 6);
    end
    exp_rd[11] = 5'd14; exp_wd[11] = 32'd204;
    j = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 6); alu_rd = 1; alu_wd = 32'd100 + 32'(c);
      lsu_valid = (j < 5); lsu_rd = 5'(10 + j); lsu_wd = 32'(200 + j);
      chk($sformatf("cont_ready_%0d", c), lsu_ready, exp_rdy[c]);
      if (exp_rdy[c] && j < 5) j++;
      step();
      chk($sformatf("cont_regw_%0d", c), RegW, (c < 11));
      chk($sformatf("cont_rd_%0d", c), Rd, exp_rd[c]);
      chk($sformatf("cont_wd_%0d", c), Wd, exp_wd[c]);
    end
    idle();
    chk("cont_pending", pending, 0);

    // issue to r9 on the same edge an r9 entry pops: set wins
    iss_valid = 1; iss_rd = 9;
    step();
    idle();
    lsu_valid = 1; lsu_rd = 9; lsu_wd = 32'h99;
    step();
    idle();
    iss_valid = 1; iss_rd = 9;
    step();
    chk("same_edge_regw", RegW, 1);
    chk("same_edge_rd", Rd, 9);
    chk("same_edge_pend", pending, 32'h200);
    idle();
    lsu_valid = 1; lsu_rd = 9; lsu_wd = 32'h9A;
    step();
    idle();
    step();
    chk("pend9_clr", pending, 0);
    chk("pend9_wd", Wd, 32'h9A);

    // wrap: 3x depth entries streamed through
    for (int i = 0; i <= 12; i++) begin
      lsu_valid = (i < 12); lsu_rd = 3; lsu_wd = 32'h1000 + 32'(i);
      chk($sformatf("wrap_ready_%0d", i), lsu_ready, 1);
      step();
      if (i == 0) chk("wrap_first", RegW, 0);
      else begin
        chk($sformatf("wrap_regw_%0d", i), RegW, 1);
        chk($sformatf("wrap_wd_%0d", i), Wd, 32'h1000 + 32'(i - 1));
      end
    end
    idle();
    step();
    chk("wrap_end", RegW, 0);

    // reset mid-run with 3 buffered entries and pending bits set
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd = 2; alu_wd = 32'(c);
      lsu_valid = 1; lsu_rd = 5'(4 + c); lsu_wd = 32'hA0 + 32'(c);
      iss_valid = (c < 2); iss_rd = 5'(4 + c);
      step();
    end
    idle();
    chk("pre_rst_pend", pending, 32'h30);
    reset = 1'b0;
    #1;
    chk("mid_rst_regw", RegW, 0);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_ready", lsu_ready, 0);
    chk("mid_rst_rd", Rd, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("post_rst_ready", lsu_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("no_stale_%0d", c), RegW, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
